// File: rtl/abs_pipe_unit.sv
// Two-stage per-lane absolute/negate unit with valid/ready handshaking on both sides
// and a saturating tally of overflowed lanes delivered downstream.
module abs_pipe_unit #(
  parameter int N     = 5,
  parameter int LANES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*N-1:0] in_data,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*N-1:0] out_data,
  output logic [LANES-1:0]   out_ovf,
  output logic [7:0]         ovf_count,
  input  logic               ovf_clr
);

  localparam logic [N-1:0] MaxPos = {1'b0, {(N-1){1'b1}}};

  logic               s1Valid_q, s1Valid_d;
  logic [LANES*N-1:0] s1Opnd_q, s1Opnd_d;
  logic [LANES-1:0]   s1AddOne_q, s1AddOne_d;
  logic [1:0]         s1Mode_q, s1Mode_d;
  logic               s2Valid_q, s2Valid_d;
  logic [LANES*N-1:0] s2Data_q, s2Data_d;
  logic [LANES-1:0]   s2Ovf_q, s2Ovf_d;
  logic [7:0]         ovfCount_q, ovfCount_d;

  logic               s2Ready;
  logic               s1Advance;
  logic               inAccept;
  logic               outAccept;
  logic [LANES*N-1:0] laneOpnd;
  logic [LANES-1:0]   laneInvert;
  logic [LANES*N-1:0] laneResult;
  logic [LANES-1:0]   laneOvf;
  logic [31:0]        ovfPop;
  logic [31:0]        ovfSum;

  assign s2Ready   = !s2Valid_q || out_ready;
  assign s1Advance = s1Valid_q && s2Ready;
  assign in_ready  = rst_n && (!s1Valid_q || s1Advance);
  assign inAccept  = in_valid && in_ready;
  assign outAccept = s2Valid_q && out_ready;

  for (genvar k = 0; k < LANES; k++) begin : gLane
    logic [N-1:0] x;
    logic [N-1:0] stored;
    logic [N-1:0] sum;
    logic         minHit;

    assign x                     = in_data[k*N +: N];
    assign laneInvert[k]         = (mode == 2'b10) || (mode[0] && x[N-1]);
    assign laneOpnd[k*N +: N]    = x ^ {N{laneInvert[k]}};

    // The most negative value is the only one whose inverted form is MaxPos.
    assign stored                = s1Opnd_q[k*N +: N];
    assign sum                   = stored + {{(N-1){1'b0}}, s1AddOne_q[k]};
    assign minHit                = s1AddOne_q[k] && (stored == MaxPos) && (s1Mode_q != 2'b00);
    assign laneResult[k*N +: N]  = (minHit && (s1Mode_q == 2'b11)) ? MaxPos : sum;
    assign laneOvf[k]            = minHit;
  end

  always_comb begin
    ovfPop = '0;
    for (int k = 0; k < LANES; k++) begin
      ovfPop = ovfPop + {31'd0, s2Ovf_q[k]};
    end
    ovfSum = {24'd0, ovfCount_q} + ovfPop;
  end

  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1Opnd_d   = s1Opnd_q;
    s1AddOne_d = s1AddOne_q;
    s1Mode_d   = s1Mode_q;
    s2Valid_d  = s2Valid_q;
    s2Data_d   = s2Data_q;
    s2Ovf_d    = s2Ovf_q;
    ovfCount_d = ovfCount_q;

    if (inAccept) begin
      s1Valid_d  = 1'b1;
      s1Opnd_d   = laneOpnd;
      s1AddOne_d = laneInvert;
      s1Mode_d   = mode;
    end else if (s1Advance) begin
      s1Valid_d  = 1'b0;
    end

    if (s1Advance) begin
      s2Valid_d = 1'b1;
      s2Data_d  = laneResult;
      s2Ovf_d   = laneOvf;
    end else if (out_ready) begin
      s2Valid_d = 1'b0;
    end

    if (ovf_clr) begin
      ovfCount_d = 8'd0;
    end else if (outAccept) begin
      ovfCount_d = (ovfSum > 32'd255) ? 8'd255 : ovfSum[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q  <= 1'b0;
      s1Opnd_q   <= '0;
      s1AddOne_q <= '0;
      s1Mode_q   <= 2'b00;
      s2Valid_q  <= 1'b0;
      s2Data_q   <= '0;
      s2Ovf_q    <= '0;
      ovfCount_q <= 8'd0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1Opnd_q   <= s1Opnd_d;
      s1AddOne_q <= s1AddOne_d;
      s1Mode_q   <= s1Mode_d;
      s2Valid_q  <= s2Valid_d;
      s2Data_q   <= s2Data_d;
      s2Ovf_q    <= s2Ovf_d;
      ovfCount_q <= ovfCount_d;
    end
  end

  assign out_valid = s2Valid_q;
  assign out_data  = s2Data_q;
  assign out_ovf   = s2Ovf_q;
  assign ovf_count = ovfCount_q;

endmodule

// File: tb/tb_abs_pipe_unit.sv
// Directed bench for abs_pipe_unit: a single-lane instance for most vectors and a
// two-lane instance for the packed-lane cases.
module tb_abs_pipe_unit;

  logic       clk;
  logic       rst_n;

  logic       inValid, inReady, outValid, outReady, ovfClr;
  logic [4:0] inData, outData;
  logic [1:0] mode;
  logic       outOvf;
  logic [7:0] ovfCount;

  logic       inValid2, inReady2, outValid2, outReady2, ovfClr2;
  logic [9:0] inData2, outData2;
  logic [1:0] mode2;
  logic [1:0] outOvf2;
  logic [7:0] ovfCount2;

  int numCompared   = 0;
  int numMismatched = 0;

  logic [4:0] absIn  [4] = '{5'b00011, 5'b11101, 5'b00000, 5'b01111};
  logic [4:0] absExp [4] = '{5'b00011, 5'b00011, 5'b00000, 5'b01111};
  logic [1:0] minMode[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [4:0] minExp [4] = '{5'b10000, 5'b10000, 5'b10000, 5'b01111};
  logic       minOvf [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic [4:0] bpIn   [6] = '{5'b00001, 5'b11110, 5'b00011, 5'b11100, 5'b00101, 5'b11010};
  logic [4:0] rx[$];

  abs_pipe_unit #(.N(5), .LANES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid), .in_ready(inReady), .in_data(inData), .mode(mode),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData), .out_ovf(outOvf),
    .ovf_count(ovfCount), .ovf_clr(ovfClr)
  );

  abs_pipe_unit #(.N(5), .LANES(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid2), .in_ready(inReady2), .in_data(inData2), .mode(mode2),
    .out_valid(outValid2), .out_ready(outReady2), .out_data(outData2), .out_ovf(outOvf2),
    .ovf_count(ovfCount2), .ovf_clr(ovfClr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] data, input logic [1:0] m);
    inValid = valid;
    inData  = data;
    mode    = m;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sendOvfBeats(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 5'b10000, 2'b11);
      nextCycle();
    end
    applyStimulus(1'b0, 5'd0, 2'b00);
    nextCycle();
    nextCycle();
    nextCycle();
  endtask

  initial begin
    int sent;
    int cyc;
    rst_n     = 1'b1;
    outReady  = 1'b1;
    ovfClr    = 1'b0;
    inValid2  = 1'b0;
    inData2   = '0;
    mode2     = 2'b00;
    outReady2 = 1'b1;
    ovfClr2   = 1'b0;
    applyStimulus(1'b0, 5'd0, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstOutValid", 32'(outValid), 32'd0);
    checkOutput("rstInReady", 32'(inReady), 32'd0);
    checkOutput("rstOutData", 32'(outData), 32'd0);
    checkOutput("rstOvfCount", 32'(ovfCount), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("relInReady", 32'(inReady), 32'd1);
    nextCycle();

    // Back-to-back abs-wrap stream: output k appears two edges after beat k is driven.
    for (int i = 0; i < 6; i++) begin
      if (i < 4) applyStimulus(1'b1, absIn[i], 2'b01);
      else       applyStimulus(1'b0, 5'd0, 2'b01);
      nextCycle();
      if (i == 0) begin
        checkOutput("absLatency", 32'(outValid), 32'd0);
      end else if (i <= 4) begin
        checkOutput("absValid", 32'(outValid), 32'd1);
        checkOutput("absData", 32'(outData), 32'(absExp[i-1]));
        checkOutput("absOvf", 32'(outOvf), 32'd0);
        checkOutput("absInReady", 32'(inReady), 32'd1);
      end
    end

    for (int i = 0; i < 6; i++) begin
      if (i < 4) applyStimulus(1'b1, 5'b10000, minMode[i]);
      else       applyStimulus(1'b0, 5'd0, 2'b00);
      nextCycle();
      if (i >= 1 && i <= 4) begin
        checkOutput("minValid", 32'(outValid), 32'd1);
        checkOutput("minData", 32'(outData), 32'(minExp[i-1]));
        checkOutput("minOvf", 32'(outOvf), 32'(minOvf[i-1]));
      end
    end
    checkOutput("minOvfCount", 32'(ovfCount), 32'd3);

    inValid2 = 1'b1;
    inData2  = {5'b00001, 5'b11111};
    mode2    = 2'b10;
    nextCycle();
    inData2  = {5'b10000, 5'b00011};
    mode2    = 2'b01;
    nextCycle();
    inValid2 = 1'b0;
    checkOutput("laneNegValid", 32'(outValid2), 32'd1);
    checkOutput("laneNegData", 32'(outData2), 32'({5'b11111, 5'b00001}));
    checkOutput("laneNegOvf", 32'(outOvf2), 32'd0);
    nextCycle();
    checkOutput("laneMixData", 32'(outData2), 32'({5'b10000, 5'b00011}));
    checkOutput("laneMixOvf", 32'(outOvf2), 32'b10);
    nextCycle();
    checkOutput("laneOvfCount", 32'(ovfCount2), 32'd1);

    // Backpressure: downstream stalls for the first four cycles of a six-beat stream.
    sent = 0;
    cyc  = 0;
    while (rx.size() < 6 && cyc < 40) begin
      outReady = (cyc >= 4);
      if (sent < 6) applyStimulus(1'b1, bpIn[sent], 2'b01);
      else          applyStimulus(1'b0, 5'd0, 2'b01);
      #1;
      if (cyc == 0) checkOutput("bpInReadyStart", 32'(inReady), 32'd1);
      if (cyc == 2 || cyc == 3) begin
        checkOutput("bpInReadyFull", 32'(inReady), 32'd0);
        checkOutput("bpHoldValid", 32'(outValid), 32'd1);
        checkOutput("bpHoldData", 32'(outData), 32'd1);
      end
      if (outValid && outReady) rx.push_back(outData);
      if (inValid && inReady) sent++;
      nextCycle();
      cyc++;
    end
    outReady = 1'b1;
    applyStimulus(1'b0, 5'd0, 2'b00);
    checkOutput("bpBeatCount", 32'(rx.size()), 32'd6);
    for (int i = 0; i < rx.size(); i++) begin
      checkOutput("bpOrder", 32'(rx[i]), 32'(i + 1));
    end
    nextCycle();

    applyStimulus(1'b1, 5'b01010, 2'b00);
    nextCycle();
    applyStimulus(1'b1, 5'b00110, 2'b00);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 2'b00);
    checkOutput("flushPreValid", 32'(outValid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("flushOutValid", 32'(outValid), 32'd0);
    checkOutput("flushOutData", 32'(outData), 32'd0);
    checkOutput("flushInReady", 32'(inReady), 32'd0);
    checkOutput("flushOvfCount", 32'(ovfCount), 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("flushRelInReady", 32'(inReady), 32'd1);
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      checkOutput("flushNoGhost", 32'(outValid), 32'd0);
      nextCycle();
    end
    applyStimulus(1'b1, 5'b00111, 2'b00);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 2'b00);
    nextCycle();
    checkOutput("flushFirstValid", 32'(outValid), 32'd1);
    checkOutput("flushFirstData", 32'(outData), 32'b00111);
    nextCycle();

    sendOvfBeats(250);
    checkOutput("ovfCount250", 32'(ovfCount), 32'd250);
    sendOvfBeats(5);
    checkOutput("ovfCount255", 32'(ovfCount), 32'd255);
    sendOvfBeats(1);
    checkOutput("ovfSaturate", 32'(ovfCount), 32'd255);

    applyStimulus(1'b1, 5'b10000, 2'b01);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 2'b00);
    nextCycle();
    checkOutput("clrOvfValid", 32'(outValid), 32'd1);
    checkOutput("clrOvfFlag", 32'(outOvf), 32'd1);
    ovfClr = 1'b1;
    nextCycle();
    ovfClr = 1'b0;
    checkOutput("clrPriority", 32'(ovfCount), 32'd0);
    nextCycle();
    checkOutput("clrStays", 32'(ovfCount), 32'd0);
    sendOvfBeats(1);
    checkOutput("clrThenCount", 32'(ovfCount), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
